sb_arbiter: RTL and testbench
=============================

// Module: sb_arbiter
// PURPOSE
//  Central SB bus arbiter. Sits directly upstream of every SB master: samples sb_busreq_mX/sb_lock_mX and drives sb_grant_mX.
//  Drives the owner select for the address/wdata mux and tracks SPLIT-parked masters until the slave releases them.
//  Round-robin by default; fixed priority when compiled with the optional macro.
// PARAMETERS
//  NUM_MASTERS   3   number of SB masters (2..8); bit i of every vector = master i
//  SEL_W         3   width of sb_master_sel, >= clog2(NUM_MASTERS)
// PORTS
//  sb_clk         in   1            bus clock; all logic on posedge
//  sb_reset       in   1            asynchronous, active-high reset
//  sb_busreq      in   NUM_MASTERS  bus requests
//  sb_lock        in   NUM_MASTERS  locked-transfer requests
//  sb_trans       in   2            HTRANS of current owner (IDLE 0, BUSY 1, NONSEQ 2, SEQ 3)
//  sb_ready       in   1            slave ready
//  sb_resp        in   2            slave response (OKAY 1, ERROR 2, SPLIT 3; 0 = no response)
//  sb_split       in   NUM_MASTERS  split-release pulses from slave, bit i frees master i
//  sb_grant       out  NUM_MASTERS  one-hot or zero grant, registered
//  sb_master_sel  out  SEL_W        index of current owner, registered; drives bus muxes
//  sb_mastlock    out  1            owner holds a locked sequence, registered
// BEHAVIOUR
//  Reset: sb_grant=0, sb_master_sel=0, sb_mastlock=0, split_mask=0, rr_ptr=0, state ARB_IDLE. Applied immediately on assert, even mid-burst.
//  Eligible set: E = sb_busreq & ~split_mask.
//  States:
//   ARB_IDLE: no owner. If E!=0, pick winner W; next edge sb_grant=1<<W, sb_master_sel=W, go ARB_OWNED.
//    Latency: busreq sampled at edge k gives grant valid after edge k+1.
//   ARB_OWNED: release when sb_ready=1 && !sb_busreq[own] && !sb_lock[own].
//    On release, pick from E in the same cycle. E!=0: grant W next edge (handover, no dead cycle). E==0: ARB_IDLE with sb_grant=0.
//    sb_lock[own]=1 blocks re-arbitration regardless of other requests. sb_mastlock <= sb_lock[own] each cycle.
//    sb_resp==SPLIT (any sb_ready): set split_mask[own], sb_mastlock<=0, re-arbitrate excluding own, go ARB_IDLE or grant W.
//    sb_resp==ERROR: no arbitration effect; owner keeps grant.
//  Winner pick (round-robin): first set bit of E scanning rr_ptr, rr_ptr+1, ... mod NUM_MASTERS.
//   On every new grant, rr_ptr <= W+1 (wraps NUM_MASTERS-1 -> 0).
//  Split release: sb_split[i]=1 clears split_mask[i] next edge; master i is eligible from the following cycle.
//   Simultaneous set and clear of the same bit: set wins.
//   sb_split bits for masters not in split_mask are ignored.
//  All masters split and requesting: grant=0, ARB_IDLE until a release.
//  Owner index stays in sb_master_sel while idle (bus mux holds last owner); sb_grant is the authority.
//  sb_trans is used only for BUSY hold: sb_trans==BUSY with sb_busreq[own]=0 still keeps the owner until sb_trans!=BUSY.
// CONFIGURATION
//  SB_ARB_FIXED_PRIO_EN defined: winner = lowest-index set bit of E. rr_ptr is removed; all other rules unchanged.
//  Undefined: round-robin as above.
// STRUCTURE
//  Shared package sb_pkg: SB_TRANS_* (IDLE/BUSY/NONSEQ/SEQ) and SB_RESP_* (OKAY/ERROR/SPLIT) constants.
//   Also the ARB_IDLE/ARB_OWNED state encoding and the RESP/TRANS widths, shared with the masters.
//  Sub-module sb_arb_pick: combinational picker (req vector, start pointer) -> winner index + valid.
//   Holds the round-robin/fixed-priority ifdef. Top keeps state, split_mask, rr_ptr and output registers.
// TESTING
//  1 Idle bus, busreq=3'b010 at edge 5 -> grant=3'b010, sel=1 after edge 6; drop busreq with ready=1 -> grant=0 next edge.
//  2 busreq=3'b111 held, owner releases each cycle -> grants rotate 001,010,100,001 with no idle cycles.
//    With SB_ARB_FIXED_PRIO_EN, master 0 keeps the grant throughout.
//  3 Owner 0 lock=1, busreq[0]=0, others requesting -> grant stays 001, mastlock=1; lock=0 with ready=1 -> grant moves to 010.
//  4 Owner 1 gets resp=SPLIT -> split_mask=010, grant moves to 100. Master 1 requests, stays ungranted.
//    sb_split=010 pulse -> master 1 granted at the next release.
//  5 sb_reset asserted mid-burst with grant=100 -> grant=0 and mastlock=0 immediately (async).
//    Deassert with busreq=001 -> grant=001 after the second edge.
//  6 Split set and sb_split for the same master in one cycle -> split_mask bit remains 1.

Source files
------------

// File: rtl/sb_pkg.sv
// sb_pkg -- shared SB bus definitions.
//   HTRANS / response encodings and widths used by the arbiter and the masters,
//   plus the arbiter state encoding (kept as plain constants so legacy masters
//   that decode the state can keep comparing against the same values).
package sb_pkg;

  localparam int unsigned SB_TRANS_W = 2;
  localparam int unsigned SB_RESP_W  = 2;

  localparam logic [SB_TRANS_W-1:0] SB_TRANS_IDLE   = 2'd0;
  localparam logic [SB_TRANS_W-1:0] SB_TRANS_BUSY   = 2'd1;
  localparam logic [SB_TRANS_W-1:0] SB_TRANS_NONSEQ = 2'd2;
  localparam logic [SB_TRANS_W-1:0] SB_TRANS_SEQ    = 2'd3;

  localparam logic [SB_RESP_W-1:0] SB_RESP_NONE  = 2'd0;
  localparam logic [SB_RESP_W-1:0] SB_RESP_OKAY  = 2'd1;
  localparam logic [SB_RESP_W-1:0] SB_RESP_ERROR = 2'd2;
  localparam logic [SB_RESP_W-1:0] SB_RESP_SPLIT = 2'd3;

  localparam logic [0:0] ARB_IDLE  = 1'b0;
  localparam logic [0:0] ARB_OWNED = 1'b1;

endpackage

// File: rtl/sb_arb_pick.sv
// sb_arb_pick -- combinational winner picker for the SB arbiter.
//   Default: round-robin, scanning i_start, i_start+1, ... mod NUM_MASTERS.
//   SB_ARB_FIXED_PRIO_EN defined: lowest-index request wins, i_start ignored.
// Ports:
//   i_req    [NUM_MASTERS-1:0]  eligible request vector
//   i_start  [SEL_W-1:0]        round-robin start index (< NUM_MASTERS)
//   o_win    [SEL_W-1:0]        winning master index (0 when none)
//   o_vld                       at least one request present
module sb_arb_pick
  import sb_pkg::*;
#(
  parameter int unsigned NUM_MASTERS = 3,
  parameter int unsigned SEL_W       = 3
) (
  input  logic [NUM_MASTERS-1:0] i_req,
  input  logic [SEL_W-1:0]       i_start,
  output logic [SEL_W-1:0]       o_win,
  output logic                   o_vld
);

`ifdef SB_ARB_FIXED_PRIO_EN
  logic w_unused_start;
  assign w_unused_start = ^i_start;

  // Descending scan so the lowest set index is the last one written.
  always_comb begin
    o_win = '0;
    o_vld = 1'b0;
    for (int unsigned i = NUM_MASTERS; i > 0; i--) begin
      if (i_req[i-1]) begin
        o_win = SEL_W'(i - 1);
        o_vld = 1'b1;
      end
    end
  end
`else
  always_comb begin
    int unsigned idx;
    idx   = 0;
    o_win = '0;
    o_vld = 1'b0;
    for (int unsigned off = 0; off < NUM_MASTERS; off++) begin
      idx = 32'(i_start) + off;
      if (idx >= NUM_MASTERS) idx = idx - NUM_MASTERS;
      if (!o_vld && i_req[idx]) begin
        o_win = SEL_W'(idx);
        o_vld = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/sb_arbiter.sv
// sb_arbiter -- central SB bus arbiter.
//   Grants the bus to one master at a time, drives the owner select for the
//   address/wdata muxes and parks SPLIT masters until the slave releases them.
//   Round-robin by default; fixed priority when SB_ARB_FIXED_PRIO_EN is defined.
// Ports:
//   sb_clk, sb_reset         clock, async active-high reset
//   sb_busreq, sb_lock       per-master request / locked-transfer request
//   sb_trans                 HTRANS of the current owner
//   sb_ready, sb_resp        slave handshake and response
//   sb_split                 per-master split-release pulses
//   sb_grant                 registered one-hot (or zero) grant
//   sb_master_sel            registered owner index for the bus muxes
//   sb_mastlock              registered: owner holds a locked sequence
module sb_arbiter
  import sb_pkg::*;
#(
  parameter int unsigned NUM_MASTERS = 3,
  parameter int unsigned SEL_W       = 3
) (
  input  logic                   sb_clk,
  input  logic                   sb_reset,
  input  logic [NUM_MASTERS-1:0] sb_busreq,
  input  logic [NUM_MASTERS-1:0] sb_lock,
  input  logic [SB_TRANS_W-1:0]  sb_trans,
  input  logic                   sb_ready,
  input  logic [SB_RESP_W-1:0]   sb_resp,
  input  logic [NUM_MASTERS-1:0] sb_split,
  output logic [NUM_MASTERS-1:0] sb_grant,
  output logic [SEL_W-1:0]       sb_master_sel,
  output logic                   sb_mastlock
);

  logic [0:0]             r_state;
  logic [NUM_MASTERS-1:0] r_split_mask;

  logic [NUM_MASTERS-1:0] w_elig;
  logic [NUM_MASTERS-1:0] w_own_oh;
  logic [NUM_MASTERS-1:0] w_pick_req;
  logic [NUM_MASTERS-1:0] w_split_set;
  logic                   w_own_req;
  logic                   w_own_lock;
  logic                   w_is_split;
  logic                   w_release;
  logic                   w_rearb;
  logic [SEL_W-1:0]       w_start;
  logic [SEL_W-1:0]       w_win;
  logic                   w_win_vld;

`ifdef SB_ARB_FIXED_PRIO_EN
  assign w_start = '0;
`else
  logic [SEL_W-1:0] r_rr_ptr;
  assign w_start = r_rr_ptr;
`endif

  always_comb begin
    w_elig     = sb_busreq & ~r_split_mask;
    w_own_oh   = NUM_MASTERS'(1) << sb_master_sel;
    w_own_req  = |(sb_busreq & w_own_oh);
    w_own_lock = |(sb_lock & w_own_oh);
    w_is_split = (r_state == ARB_OWNED) && (sb_resp == SB_RESP_SPLIT);
    // BUSY keeps the owner even with its request dropped.
    w_release  = (r_state == ARB_OWNED) && sb_ready && !w_own_req && !w_own_lock &&
                 (sb_trans != SB_TRANS_BUSY);
    w_rearb    = (r_state == ARB_IDLE) || w_is_split || w_release;
    // The split owner is not yet in r_split_mask this cycle, so exclude it here.
    w_pick_req  = w_is_split ? (w_elig & ~w_own_oh) : w_elig;
    w_split_set = w_is_split ? w_own_oh : '0;
  end

  sb_arb_pick #(
    .NUM_MASTERS (NUM_MASTERS),
    .SEL_W       (SEL_W)
  ) u_pick (
    .i_req   (w_pick_req),
    .i_start (w_start),
    .o_win   (w_win),
    .o_vld   (w_win_vld)
  );

  always_ff @(posedge sb_clk or posedge sb_reset) begin
    if (sb_reset) begin
      r_state       <= ARB_IDLE;
      r_split_mask  <= '0;
      sb_grant      <= '0;
      sb_master_sel <= '0;
      sb_mastlock   <= 1'b0;
    end else begin
      // Set after clear: a split arriving with its own release stays parked.
      r_split_mask <= (r_split_mask & ~sb_split) | w_split_set;
      if (w_rearb) begin
        sb_mastlock <= 1'b0;
        if (w_win_vld) begin
          r_state       <= ARB_OWNED;
          sb_grant      <= NUM_MASTERS'(1) << w_win;
          sb_master_sel <= w_win;
        end else begin
          r_state  <= ARB_IDLE;
          sb_grant <= '0;
        end
      end else begin
        sb_mastlock <= w_own_lock;
      end
    end
  end

`ifndef SB_ARB_FIXED_PRIO_EN
  always_ff @(posedge sb_clk or posedge sb_reset) begin
    if (sb_reset) begin
      r_rr_ptr <= '0;
    end else if (w_rearb && w_win_vld) begin
      r_rr_ptr <= (w_win == SEL_W'(NUM_MASTERS - 1)) ? '0 : w_win + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_sb_arbiter.sv
module tb_sb_arbiter;

  logic       sb_clk;
  logic       sb_reset;
  logic [2:0] sb_busreq;
  logic [2:0] sb_lock;
  logic [1:0] sb_trans;
  logic       sb_ready;
  logic [1:0] sb_resp;
  logic [2:0] sb_split;
  logic [2:0] sb_grant;
  logic [2:0] sb_master_sel;
  logic       sb_mastlock;

  int n_pass;
  int n_total;

  sb_arbiter #(
    .NUM_MASTERS (3),
    .SEL_W       (3)
  ) dut (
    .sb_clk        (sb_clk),
    .sb_reset      (sb_reset),
    .sb_busreq     (sb_busreq),
    .sb_lock       (sb_lock),
    .sb_trans      (sb_trans),
    .sb_ready      (sb_ready),
    .sb_resp       (sb_resp),
    .sb_split      (sb_split),
    .sb_grant      (sb_grant),
    .sb_master_sel (sb_master_sel),
    .sb_mastlock   (sb_mastlock)
  );

  initial sb_clk = 1'b0;
  always #5 sb_clk = ~sb_clk;

  typedef struct {
    logic [2:0] busreq;
    logic [2:0] lock;
    logic [1:0] trans;
    logic       ready;
    logic [1:0] resp;
    logic [2:0] split;
    logic [2:0] grant;
    logic [2:0] sel;
    logic       ml;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic [2:0] busreq, logic [2:0] lock, logic [1:0] trans,
                              logic ready, logic [1:0] resp, logic [2:0] split,
                              logic [2:0] grant, logic [2:0] sel, logic ml);
    vec_t v;
    v.busreq = busreq; v.lock = lock; v.trans = trans; v.ready = ready;
    v.resp = resp; v.split = split; v.grant = grant; v.sel = sel; v.ml = ml;
    return v;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic chk_all(input string tag, input logic [2:0] g, input logic [2:0] s, input logic m);
    chk({tag, ".grant"},    8'(sb_grant),      8'(g));
    chk({tag, ".sel"},      8'(sb_master_sel), 8'(s));
    chk({tag, ".mastlock"}, 8'(sb_mastlock),   8'(m));
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;

    // busreq lock trans ready resp split | grant sel ml
    // 1: single request, grant, release to idle
    vecs.push_back(mk(3'b000, 3'b000, 2'd0, 1'b1, 2'd0, 3'b000, 3'b000, 3'd0, 1'b0));
    vecs.push_back(mk(3'b010, 3'b000, 2'd0, 1'b1, 2'd0, 3'b000, 3'b010, 3'd1, 1'b0));
    vecs.push_back(mk(3'b010, 3'b000, 2'd0, 1'b0, 2'd0, 3'b000, 3'b010, 3'd1, 1'b0));
    vecs.push_back(mk(3'b000, 3'b000, 2'd0, 1'b1, 2'd0, 3'b000, 3'b000, 3'd1, 1'b0));
    // 2: rotation with owner dropping its request each cycle (rr_ptr=2 here)
    vecs.push_back(mk(3'b111, 3'b000, 2'd0, 1'b1, 2'd0, 3'b000, 3'b100, 3'd2, 1'b0));
    vecs.push_back(mk(3'b011, 3'b000, 2'd0, 1'b1, 2'd0, 3'b000, 3'b001, 3'd0, 1'b0));
    vecs.push_back(mk(3'b110, 3'b000, 2'd0, 1'b1, 2'd0, 3'b000, 3'b010, 3'd1, 1'b0));
    vecs.push_back(mk(3'b101, 3'b000, 2'd0, 1'b1, 2'd0, 3'b000, 3'b100, 3'd2, 1'b0));
    vecs.push_back(mk(3'b011, 3'b000, 2'd0, 1'b1, 2'd0, 3'b000, 3'b001, 3'd0, 1'b0));
    // 3: locked owner 0 holds against others
    vecs.push_back(mk(3'b110, 3'b001, 2'd0, 1'b1, 2'd0, 3'b000, 3'b001, 3'd0, 1'b1));
    vecs.push_back(mk(3'b110, 3'b001, 2'd0, 1'b1, 2'd0, 3'b000, 3'b001, 3'd0, 1'b1));
    vecs.push_back(mk(3'b110, 3'b000, 2'd0, 1'b0, 2'd0, 3'b000, 3'b001, 3'd0, 1'b0));
    vecs.push_back(mk(3'b110, 3'b000, 2'd0, 1'b1, 2'd0, 3'b000, 3'b010, 3'd1, 1'b0));
    // BUSY hold with owner's request dropped
    vecs.push_back(mk(3'b100, 3'b000, 2'd1, 1'b1, 2'd0, 3'b000, 3'b010, 3'd1, 1'b0));
    // 4: SPLIT on owner 1 -> master 2, master 1 parked until released
    vecs.push_back(mk(3'b110, 3'b000, 2'd0, 1'b0, 2'd3, 3'b000, 3'b100, 3'd2, 1'b0));
    vecs.push_back(mk(3'b110, 3'b000, 2'd0, 1'b1, 2'd0, 3'b000, 3'b100, 3'd2, 1'b0));
    vecs.push_back(mk(3'b010, 3'b000, 2'd0, 1'b1, 2'd0, 3'b000, 3'b000, 3'd2, 1'b0));
    vecs.push_back(mk(3'b010, 3'b000, 2'd0, 1'b1, 2'd0, 3'b000, 3'b000, 3'd2, 1'b0));
    vecs.push_back(mk(3'b010, 3'b000, 2'd0, 1'b1, 2'd0, 3'b010, 3'b000, 3'd2, 1'b0));
    vecs.push_back(mk(3'b010, 3'b000, 2'd0, 1'b1, 2'd0, 3'b000, 3'b010, 3'd1, 1'b0));
    // 6: split set and release for the same master in one cycle -> stays parked
    vecs.push_back(mk(3'b010, 3'b000, 2'd0, 1'b1, 2'd3, 3'b010, 3'b000, 3'd1, 1'b0));
    vecs.push_back(mk(3'b010, 3'b000, 2'd0, 1'b1, 2'd0, 3'b000, 3'b000, 3'd1, 1'b0));
    vecs.push_back(mk(3'b010, 3'b000, 2'd0, 1'b1, 2'd0, 3'b010, 3'b000, 3'd1, 1'b0));
    vecs.push_back(mk(3'b010, 3'b000, 2'd0, 1'b1, 2'd0, 3'b000, 3'b010, 3'd1, 1'b0));
    // ERROR has no arbitration effect; split pulse for unparked master ignored
    vecs.push_back(mk(3'b011, 3'b000, 2'd0, 1'b1, 2'd2, 3'b000, 3'b010, 3'd1, 1'b0));
    vecs.push_back(mk(3'b011, 3'b000, 2'd0, 1'b1, 2'd0, 3'b001, 3'b010, 3'd1, 1'b0));
    vecs.push_back(mk(3'b001, 3'b000, 2'd0, 1'b1, 2'd0, 3'b000, 3'b001, 3'd0, 1'b0));

    sb_reset = 1'b0; sb_busreq = '0; sb_lock = '0; sb_trans = 2'd0;
    sb_ready = 1'b1; sb_resp = 2'd0; sb_split = '0;
    #1 sb_reset = 1'b1;
    #1 chk_all("reset", 3'b000, 3'd0, 1'b0);
    @(negedge sb_clk);
    sb_reset = 1'b0;

    foreach (vecs[i]) begin
      sb_busreq = vecs[i].busreq;
      sb_lock   = vecs[i].lock;
      sb_trans  = vecs[i].trans;
      sb_ready  = vecs[i].ready;
      sb_resp   = vecs[i].resp;
      sb_split  = vecs[i].split;
      @(posedge sb_clk);
      #1 chk_all($sformatf("vec%0d", i), vecs[i].grant, vecs[i].sel, vecs[i].ml);
      @(negedge sb_clk);
    end

    // 5: async reset mid-burst with master 2 owning a locked sequence
    sb_busreq = 3'b100; sb_lock = 3'b000; sb_trans = 2'd3; sb_ready = 1'b1;
    sb_resp = 2'd0; sb_split = 3'b000;
    @(posedge sb_clk);
    #1 chk_all("rst.own", 3'b100, 3'd2, 1'b0);
    @(negedge sb_clk);
    sb_lock = 3'b100;
    @(posedge sb_clk);
    #1 chk_all("rst.lock", 3'b100, 3'd2, 1'b1);
    #2 sb_reset = 1'b1;
    #1 chk_all("rst.async", 3'b000, 3'd0, 1'b0);
    @(negedge sb_clk);
    sb_busreq = 3'b001; sb_lock = 3'b000; sb_trans = 2'd0;
    @(posedge sb_clk);
    #1 chk_all("rst.held", 3'b000, 3'd0, 1'b0);
    @(negedge sb_clk);
    sb_reset = 1'b0;
    @(posedge sb_clk);
    #1 chk_all("rst.regrant", 3'b001, 3'd0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
